// File: rtl/platform_top_pkg.sv
// Shared defaults for the platform_top FIFO slice: data width, depth and pointer width.
`timescale 1ns/1ps
package platform_top_pkg;
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_DEPTH  = 512;
  localparam int unsigned DEF_ADDR_W = $clog2(DEF_DEPTH);
endpackage

// File: rtl/platform_top_sync_fifo.sv
// Single-clock FIFO: memory, read/write pointers, occupancy count, flags and registered read word.
`timescale 1ns/1ps
module sync_fifo
  import platform_top_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              push,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              pop;

  assign full  = (count_q == (ADDR_W+1)'(DEPTH));
  assign empty = (count_q == '0);
  // Flags come from the registered count, so a push and a pop in one cycle are judged independently.
  assign push  = wr_en & ~full;
  assign pop   = rd_en & ~empty;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
      rd_data_d = mem[rd_ptr_q];
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: the storage array has no reset; stale contents are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so all flops sample together.
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/platform_top.sv
// Platform top: counting write-data generator feeding a sync_fifo; led shows the last popped word.
`timescale 1ns/1ps
module platform_top
  import platform_top_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              clk_ip,
  input  logic              write_enable,
  input  logic              read_enable,
  output logic [DATA_W-1:0] led
);

  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              fifo_push;
  logic              fifo_full;
  logic              fifo_empty;

  // clk_ip is a legacy pin with nothing behind it.
  logic       unused_clk_ip;
  logic [1:0] unused_flags;
  assign unused_clk_ip = clk_ip;
  assign unused_flags  = {fifo_full, fifo_empty};

  always_comb begin
    wr_data_d = wr_data_q;
    if (fifo_push) wr_data_d = wr_data_q + DATA_W'(1);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) wr_data_q <= '0;
    else       wr_data_q <= wr_data_d;
  end

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (nrst),
    .wr_en   (write_enable),
    .rd_en   (read_enable),
    .wr_data (wr_data_q),
    .rd_data (led),
    .push    (fifo_push),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_platform_top.sv
// Self-checking bench for platform_top: queue-based reference model plus a table of hand-computed vectors.
`timescale 1ns/1ps
module tb_platform_top;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 512;

  logic              clk = 1'b0;
  logic              nrst = 1'b0;
  logic              clk_ip = 1'b0;
  logic              write_enable = 1'b0;
  logic              read_enable = 1'b0;
  logic [DATA_W-1:0] led;

  int checks = 0;
  int failures = 0;
  int clk_ip_mode = 0;

  // Reference model: the FIFO is a plain queue, the generator a wrapping integer.
  logic [DATA_W-1:0] model_q [$];
  int                model_gen = 0;
  logic [DATA_W-1:0] model_led = '0;

  typedef struct {
    bit                we;
    bit                re;
    logic [DATA_W-1:0] led;
    bit                empty;
    bit                full;
  } vec_t;

  vec_t vecs [$];

  platform_top dut (
    .clk          (clk),
    .nrst         (nrst),
    .clk_ip       (clk_ip),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .led          (led)
  );

  always #5 clk = ~clk;

  always #2.5 begin
    case (clk_ip_mode)
      0:       clk_ip = ~clk_ip;
      1:       clk_ip = 1'b0;
      default: clk_ip = 1'b1;
    endcase
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    model_gen = 0;
    model_led = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    write_enable = 1'b0;
    read_enable  = 1'b0;
    nrst = 1'b0;
    model_reset();
    #1;
    check("reset_led", 32'(led), 32'(0));
    check("reset_empty", 32'(dut.u_fifo.empty), 32'(1));
    check("reset_full", 32'(dut.u_fifo.full), 32'(0));
    check("reset_wr_data", 32'(dut.wr_data_q), 32'(0));
    #99;
    @(negedge clk);
    nrst = 1'b1;
  endtask

  // One clock: drive at the falling edge, advance the model at the rising edge, compare 1 ns later.
  task automatic step(input bit we, input bit re);
    bit do_push, do_pop;
    @(negedge clk);
    write_enable = we;
    read_enable  = re;
    @(posedge clk);
    do_push = we && (model_q.size() < DEPTH);
    do_pop  = re && (model_q.size() > 0);
    if (do_pop) model_led = model_q.pop_front();
    if (do_push) begin
      model_q.push_back(DATA_W'(model_gen));
      model_gen = (model_gen + 1) % (1 << DATA_W);
    end
    #1;
    check("led", 32'(led), 32'(model_led));
    check("empty", 32'(dut.u_fifo.empty), 32'(model_q.size() == 0));
    check("full", 32'(dut.u_fifo.full), 32'(model_q.size() == DEPTH));
  endtask

  task automatic fill_drain();
    int full_seen_at;
    full_seen_at = -1;
    for (int i = 0; i < 550; i++) begin
      step(1'b1, 1'b0);
      if (full_seen_at < 0 && dut.u_fifo.full) full_seen_at = i + 1;
    end
    check("fill_full_at_push", 32'(full_seen_at), 32'(512));
    check("fill_wr_data_wrapped", 32'(dut.wr_data_q), 32'(0));
    check("fill_led_idle", 32'(led), 32'(0));
    for (int i = 0; i < 550; i++) begin
      step(1'b0, 1'b1);
      if (i < 512) check("drain_seq", 32'(led), 32'(i % 256));
    end
    check("drain_led_hold", 32'(led), 32'(255));
    check("drain_empty", 32'(dut.u_fifo.empty), 32'(1));
  endtask

  task automatic add_vec(input bit we, input bit re, input int l, input bit e, input bit f);
    vec_t v;
    v.we = we; v.re = re; v.led = DATA_W'(l); v.empty = e; v.full = f;
    vecs.push_back(v);
  endtask

  initial begin
    // Concurrent push/pop table, then the empty-FIFO corner where a push cannot unblock a same-cycle pop.
    for (int i = 0; i < 3; i++)  add_vec(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) add_vec(1, 1, i, 0, 0);
    add_vec(0, 1, 10, 0, 0);
    add_vec(0, 1, 11, 0, 0);
    add_vec(0, 1, 12, 1, 0);
    add_vec(0, 1, 12, 1, 0);
    add_vec(1, 1, 12, 0, 0);
    add_vec(0, 1, 13, 1, 0);

    do_reset();

    // Fill/drain under each clk_ip behaviour; the model demands the same led sequence every time.
    for (int m = 0; m < 3; m++) begin
      clk_ip_mode = m;
      do_reset();
      fill_drain();
    end
    clk_ip_mode = 0;

    do_reset();
    foreach (vecs[i]) begin
      step(vecs[i].we, vecs[i].re);
      check("vec_led", 32'(led), 32'(vecs[i].led));
      check("vec_empty", 32'(dut.u_fifo.empty), 32'(vecs[i].empty));
      check("vec_full", 32'(dut.u_fifo.full), 32'(vecs[i].full));
    end

    // Full FIFO: a same-cycle pop does not make room for a push.
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("full_pop_led", 32'(led), 32'(0));
    check("full_push_blocked_wr_data", 32'(dut.wr_data_q), 32'(0));
    step(1'b0, 1'b1);
    check("full_next_pop", 32'(led), 32'(1));

    // Reset in the middle of a drain.
    do_reset();
    for (int i = 0; i < 200; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 100; i++) step(1'b0, 1'b1);
    check("middrain_led_before", 32'(led), 32'(99));
    @(negedge clk);
    read_enable = 1'b0;
    nrst = 1'b0;
    model_reset();
    #1;
    check("middrain_led_async", 32'(led), 32'(0));
    check("middrain_empty", 32'(dut.u_fifo.empty), 32'(1));
    #100;
    @(negedge clk);
    nrst = 1'b1;
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    check("middrain_first_word", 32'(led), 32'(0));

    // Randomised traffic with phases biased toward full, toward empty and balanced.
    do_reset();
    for (int p = 0; p < 12; p++) begin
      int wb, rb;
      case (p % 3)
        0:       begin wb = 90; rb = 15; end
        1:       begin wb = 15; rb = 90; end
        default: begin wb = 50; rb = 50; end
      endcase
      for (int i = 0; i < 300; i++)
        step($urandom_range(0, 99) < wb, $urandom_range(0, 99) < rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
